// File: rtl/apb_master_if.sv
// Command/response channel and APB bus bundle for the UART register APB initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
`timescale 1ns/1ps
interface apb_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: one accepted command becomes one SETUP/ACCESS transfer, with a
// bounded ACCESS phase and a held response channel. All bus outputs are registered.
`timescale 1ns/1ps
module apb_master #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_master_if.master  bus
);

  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.cmd_valid) begin
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        // pready is checked first so a completing slave beats the timeout.
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a register-file APB slave plus a command-level
// reference memory; expected latency, data and error come from transfer-level rules.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  apb_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  // Slave register file: written only on a completed, error-free APB write.
  logic [DW-1:0] slave_mem [4] = '{default: '0};
  logic [DW-1:0] ref_mem   [4] = '{default: '0};
  logic          force_ff = 1'b0;

  always_comb bus.prdata = force_ff ? 8'hFF : slave_mem[bus.paddr];

  always @(posedge pclk)
    if (presetn && bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
      slave_mem[bus.paddr] <= bus.pwdata;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One command through to its response; bp = cycles of rsp_ready low with a
  // second command held on cmd_valid.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input int waits, input logic serr, input int bp);
    logic          timed_out, exp_err;
    logic [DW-1:0] exp_rd;
    int            last;
    timed_out = (waits >= TO);
    exp_err   = timed_out || serr;
    exp_rd    = (wr || exp_err) ? '0 : ref_mem[addr];
    last      = timed_out ? TO - 1 : waits;

    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_psel", bus.psel, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    tick();
    bus.cmd_valid = 1'b0;
    check("setup_psel", bus.psel, 1);
    check("setup_penable", bus.penable, 0);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    check("setup_paddr", bus.paddr, addr);
    check("setup_pwrite", bus.pwrite, wr);
    check("setup_pwdata", bus.pwdata, wd);
    tick();
    for (int acc = 0; acc <= last; acc++) begin
      check("access_psel", bus.psel, 1);
      check("access_penable", bus.penable, 1);
      check("access_paddr", bus.paddr, addr);
      check("access_pwdata", bus.pwdata, wd);
      check("access_rsp_valid", bus.rsp_valid, 0);
      bus.pready  = (acc == waits);
      bus.pslverr = (acc == waits) && serr;
      force_ff    = (acc == waits) && serr && !wr;
      tick();
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      force_ff    = 1'b0;
    end
    if (wr && !exp_err) ref_mem[addr] = wd;

    bus.cmd_valid = (bp > 0);
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = AW'($urandom_range(0, 3));
    bus.cmd_wdata = DW'($urandom_range(0, 255));
    for (int i = 0; i <= bp; i++) begin
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_err", bus.rsp_err, exp_err);
      check("rsp_rdata", bus.rsp_rdata, exp_rd);
      check("resp_psel", bus.psel, 0);
      check("resp_penable", bus.penable, 0);
      check("resp_cmd_ready", bus.cmd_ready, 0);
      if (i < bp) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("done_rsp_valid", bus.rsp_valid, 0);
    check("done_cmd_ready", bus.cmd_ready, 1);
    check("done_psel", bus.psel, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    #12;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    presetn = 1'b1;
    tick();

    xfer(1'b1, 2'd0, 8'h1A, 0, 1'b0, 0);   // write, zero wait
    xfer(1'b1, 2'd3, 8'h5C, 0, 1'b0, 0);
    xfer(1'b0, 2'd3, 8'h00, 2, 1'b0, 0);   // read, two wait states
    xfer(1'b0, 2'd1, 8'h00, 20, 1'b0, 0);  // stuck slave -> timeout
    xfer(1'b0, 2'd3, 8'h00, 0, 1'b1, 0);   // slave error on read
    xfer(1'b1, 2'd2, 8'h77, 1, 1'b0, 4);   // response back-pressure
    xfer(1'b0, 2'd2, 8'h00, 0, 1'b0, 0);
    xfer(1'b0, 2'd0, 8'h00, TO - 1, 1'b0, 0); // pready on the last allowed cycle

    // Reset during ACCESS: outputs drop at once and the write never lands.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 2'd2;
    bus.cmd_wdata = 8'hAA;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    check("midrst_psel", bus.psel, 0);
    check("midrst_penable", bus.penable, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    #1 presetn = 1'b1;
    tick();
    check("postrst_cmd_ready", bus.cmd_ready, 1);
    check("postrst_psel", bus.psel, 0);
    xfer(1'b0, 2'd2, 8'h00, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      int wt;
      wt = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
      xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)),
           wt, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
